deserializer_8b10b: RTL and testbench

Bit-serial receive path for the SerDes link. The block shifts in one line bit per clock, hunts for the K28.5 comma to find code-group alignment, then decodes each aligned 10-bit code group back to an 8-bit byte. It checks code validity and running disparity on every group and tracks lock. It sits at the receive end of the link, facing the serializer's `o_Ser_Data`, and delivers bytes to the downstream data path.

---
 rtl/serdes_pkg.sv | 88 ++++++++
 rtl/decoder_8b10b.sv | 65 ++++++
 rtl/deserializer_8b10b.sv | 110 +++++++++++
 tb/tb_deserializer_8b10b.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared 8b/10b receive constants, state encoding and sub-block decode functions.
package serdes_pkg;

  localparam logic signed [1:0] RD_NEG = 2'sb11;
  localparam logic signed [1:0] RD_POS = 2'sb01;

  localparam logic [9:0] K28_5_NEG  = 10'b0011111010;
  localparam logic [9:0] K28_5_POS  = 10'b1100000101;
  localparam logic [7:0] K28_5_BYTE = 8'hBC;

  localparam logic [5:0] K28_6B_NEG = 6'b001111;
  localparam logic [5:0] K28_6B_POS = 6'b110000;
  localparam logic [3:0] K28_4B_NEG = 4'b1010;
  localparam logic [3:0] K28_4B_POS = 4'b0101;

  typedef enum logic {ST_HUNT, ST_LOCKED} rx_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] data;
  } dec5_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] data;
  } dec3_t;

  // abcdei -> EDCBA, both RD columns accepted; K28 codes handled by the caller
  function automatic dec5_t dec6b5b(input logic [5:0] c);
    dec5_t r;
    r = '0;
    case (c)
      6'b100111, 6'b011000: r = {1'b1, 5'd0};
      6'b011101, 6'b100010: r = {1'b1, 5'd1};
      6'b101101, 6'b010010: r = {1'b1, 5'd2};
      6'b110001:            r = {1'b1, 5'd3};
      6'b110101, 6'b001010: r = {1'b1, 5'd4};
      6'b101001:            r = {1'b1, 5'd5};
      6'b011001:            r = {1'b1, 5'd6};
      6'b111000, 6'b000111: r = {1'b1, 5'd7};
      6'b111001, 6'b000110: r = {1'b1, 5'd8};
      6'b100101:            r = {1'b1, 5'd9};
      6'b010101:            r = {1'b1, 5'd10};
      6'b110100:            r = {1'b1, 5'd11};
      6'b001101:            r = {1'b1, 5'd12};
      6'b101100:            r = {1'b1, 5'd13};
      6'b011100:            r = {1'b1, 5'd14};
      6'b010111, 6'b101000: r = {1'b1, 5'd15};
      6'b011011, 6'b100100: r = {1'b1, 5'd16};
      6'b100011:            r = {1'b1, 5'd17};
      6'b010011:            r = {1'b1, 5'd18};
      6'b110010:            r = {1'b1, 5'd19};
      6'b001011:            r = {1'b1, 5'd20};
      6'b101010:            r = {1'b1, 5'd21};
      6'b011010:            r = {1'b1, 5'd22};
      6'b111010, 6'b000101: r = {1'b1, 5'd23};
      6'b110011, 6'b001100: r = {1'b1, 5'd24};
      6'b100110:            r = {1'b1, 5'd25};
      6'b010110:            r = {1'b1, 5'd26};
      6'b110110, 6'b001001: r = {1'b1, 5'd27};
      6'b001110:            r = {1'b1, 5'd28};
      6'b101110, 6'b010001: r = {1'b1, 5'd29};
      6'b011110, 6'b100001: r = {1'b1, 5'd30};
      6'b101011, 6'b010100: r = {1'b1, 5'd31};
      default:              r = '0;
    endcase
    return r;
  endfunction

  // fghj -> HGF; P7 and A7 both map to 7
  function automatic dec3_t dec4b3b(input logic [3:0] c);
    dec3_t r;
    r = '0;
    case (c)
      4'b1011, 4'b0100:                   r = {1'b1, 3'd0};
      4'b1001:                            r = {1'b1, 3'd1};
      4'b0101:                            r = {1'b1, 3'd2};
      4'b1100, 4'b0011:                   r = {1'b1, 3'd3};
      4'b1101, 4'b0010:                   r = {1'b1, 3'd4};
      4'b1010:                            r = {1'b1, 3'd5};
      4'b0110:                            r = {1'b1, 3'd6};
      4'b1110, 4'b0001, 4'b0111, 4'b1000: r = {1'b1, 3'd7};
      default:                            r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decoder_8b10b.sv
// Combinational 10b->8b decode with code validity and running disparity check.
module decoder_8b10b
  import serdes_pkg::*;
(
  input  logic [9:0]        code,
  input  logic signed [1:0] rd_in,
  output logic [7:0]        data,
  output logic              k,
  output logic              code_err,
  output logic              disp_err,
  output logic signed [1:0] rd_out
);

  dec5_t      d6;
  dec3_t      d4;
  logic [3:0] ones;

  // Sub-block decode, K28 pairing rule, then ones-count disparity rule
  always_comb begin
    d6       = dec6b5b(code[9:4]);
    d4       = dec4b3b(code[3:0]);
    data     = '0;
    k        = 1'b0;
    code_err = 1'b0;
    disp_err = 1'b0;
    rd_out   = rd_in;
    ones     = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      ones = ones + 4'(code[i]);
    end

    if (code[9:4] == K28_6B_NEG || code[9:4] == K28_6B_POS) begin
      if ((code[9:4] == K28_6B_NEG && code[3:0] == K28_4B_NEG) ||
          (code[9:4] == K28_6B_POS && code[3:0] == K28_4B_POS)) begin
        k    = 1'b1;
        data = K28_5_BYTE;
      end else begin
        code_err = 1'b1;
      end
    end else if (d6.valid && d4.valid) begin
      data = {d4.data, d6.data};
    end else begin
      code_err = 1'b1;
    end

    case (ones)
      4'd5: ;
      4'd6: begin
        disp_err = (rd_in != RD_NEG);
        rd_out   = RD_POS;
      end
      4'd4: begin
        disp_err = (rd_in != RD_POS);
        rd_out   = RD_NEG;
      end
      default: code_err = 1'b1;
    endcase

    if (code_err) begin
      data = '0;
      k    = 1'b0;
    end
  end

endmodule

// File: rtl/deserializer_8b10b.sv
// Serial receive path: comma hunt, word alignment, 8b/10b decode and lock tracking.
module deserializer_8b10b
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LOSS_CNT   = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_rst,
  input  logic                  i_Ser_Data,
  output logic [DATA_WIDTH-1:0] o_Data,
  output logic                  o_Valid,
  output logic                  o_K,
  output logic                  o_Code_Err,
  output logic                  o_Disp_Err,
  output logic                  o_Locked,
  output logic [9:0]            o_10B,
  output logic signed [1:0]     o_RD
);

  localparam logic [3:0] LOSS_LIM = 4'(LOSS_CNT);

  rx_state_t         state;
  logic [9:0]        window;
  logic [3:0]        bit_cnt;
  logic [3:0]        err_cnt;
  logic [7:0]        dec_data;
  logic              dec_k;
  logic              dec_code_err;
  logic              dec_disp_err;
  logic signed [1:0] dec_rd;
  logic              comma_hit;

  decoder_8b10b u_decoder (
    .code     (window),
    .rd_in    (o_RD),
    .data     (dec_data),
    .k        (dec_k),
    .code_err (dec_code_err),
    .disp_err (dec_disp_err),
    .rd_out   (dec_rd)
  );

  assign comma_hit = (window == K28_5_NEG) || (window == K28_5_POS);

  // Window shift, hunt/lock state machine and registered word outputs
  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      state      <= ST_HUNT;
      window     <= '0;
      bit_cnt    <= '0;
      err_cnt    <= '0;
      o_Data     <= '0;
      o_Valid    <= 1'b0;
      o_K        <= 1'b0;
      o_Code_Err <= 1'b0;
      o_Disp_Err <= 1'b0;
      o_Locked   <= 1'b0;
      o_10B      <= '0;
      o_RD       <= RD_NEG;
    end else begin
      window  <= {i_Ser_Data, window[9:1]};
      o_Valid <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (comma_hit) begin
            o_Valid    <= 1'b1;
            o_K        <= 1'b1;
            o_Data     <= DATA_WIDTH'(K28_5_BYTE);
            o_Code_Err <= 1'b0;
            o_Disp_Err <= 1'b0;
            o_10B      <= window;
            o_Locked   <= 1'b1;
            o_RD       <= (window == K28_5_NEG) ? RD_POS : RD_NEG;
            bit_cnt    <= '0;
            err_cnt    <= '0;
            state      <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (bit_cnt == 4'd9) begin
            bit_cnt    <= '0;
            o_Valid    <= 1'b1;
            o_K        <= dec_k;
            o_Data     <= DATA_WIDTH'(dec_data);
            o_Code_Err <= dec_code_err;
            o_Disp_Err <= dec_disp_err;
            o_10B      <= window;
            o_RD       <= dec_rd;
            if (!dec_code_err) begin
              err_cnt <= '0;
            end else if (err_cnt + 4'd1 >= LOSS_LIM) begin
              // lock loss overrides the decoded RD and drops back to hunting
              err_cnt  <= '0;
              o_Locked <= 1'b0;
              o_RD     <= RD_NEG;
              state    <= ST_HUNT;
            end else begin
              err_cnt <= err_cnt + 4'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer_8b10b.sv
// Scoreboard bench for deserializer_8b10b: words pushed when driven, checked on o_Valid.
module tb_deserializer_8b10b;

  logic       i_Clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_Ser_Data = 1'b0;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       o_K;
  logic       o_Code_Err;
  logic       o_Disp_Err;
  logic       o_Locked;
  logic [9:0] o_10B;
  logic [1:0] o_RD;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  typedef struct {
    logic [9:0] tenb;
    logic [7:0] data;
    logic       k;
    logic       cerr;
    logic       derr;
    logic       locked;
    logic [1:0] rd;
    int         when;
  } exp_t;

  exp_t sb[$];

  deserializer_8b10b #(.DATA_WIDTH(8), .LOSS_CNT(4)) dut (
    .i_Clk      (i_Clk),
    .i_rst      (i_rst),
    .i_Ser_Data (i_Ser_Data),
    .o_Data     (o_Data),
    .o_Valid    (o_Valid),
    .o_K        (o_K),
    .o_Code_Err (o_Code_Err),
    .o_Disp_Err (o_Disp_Err),
    .o_Locked   (o_Locked),
    .o_10B      (o_10B),
    .o_RD       (o_RD)
  );

  always #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic drive_bit(input logic b);
    i_Ser_Data = b;
    @(posedge i_Clk);
    #1;
  endtask

  // Bits go out LSB first; expectation is due one edge after the last bit is sampled
  task automatic send_word(input logic [9:0] w, input logic [7:0] d, input logic k,
                           input logic cerr, input logic derr, input logic locked,
                           input logic [1:0] rd);
    exp_t e;
    for (int i = 0; i < 10; i++) drive_bit(w[i]);
    e.tenb = w; e.data = d; e.k = k; e.cerr = cerr; e.derr = derr;
    e.locked = locked; e.rd = rd; e.when = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"},   32'(o_Data), 32'h00);
    check({tag, "_valid"},  32'(o_Valid), 32'h0);
    check({tag, "_k"},      32'(o_K), 32'h0);
    check({tag, "_cerr"},   32'(o_Code_Err), 32'h0);
    check({tag, "_derr"},   32'(o_Disp_Err), 32'h0);
    check({tag, "_locked"}, 32'(o_Locked), 32'h0);
    check({tag, "_10b"},    32'(o_10B), 32'h000);
    check({tag, "_rd"},     32'(o_RD), 32'h3);
  endtask

  // Output monitor: every o_Valid pulse must match the oldest pending expectation
  always @(posedge i_Clk) begin
    exp_t e;
    #1;
    if (o_Valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(o_Valid), 32'h0);
      end else begin
        e = sb.pop_front();
        check("when",   cyc, e.when);
        check("10b",    32'(o_10B), 32'(e.tenb));
        check("data",   32'(o_Data), 32'(e.data));
        check("k",      32'(o_K), 32'(e.k));
        check("cerr",   32'(o_Code_Err), 32'(e.cerr));
        check("derr",   32'(o_Disp_Err), 32'(e.derr));
        check("locked", 32'(o_Locked), 32'(e.locked));
        check("rd",     32'(o_RD), 32'(e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) drive_bit(1'b0);
    check_reset_vals("rst");
    i_rst = 1'b0;

    // Random prefix then RD- comma: lock, K28.5, RD becomes +1
    repeat (3) drive_bit(1'($urandom_range(0, 1)));
    check("prelock", 32'(o_Locked), 32'h0);
    send_word(10'b0011111010, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
    // D0.0 RD+ column, neutral
    send_word(10'b0110001011, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    // Seven ones: code error, RD unchanged
    send_word(10'b1001111011, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    // Neutral D0.0, then a six-ones D0.5 while RD is +1
    send_word(10'b1001110100, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    send_word(10'b1001111010, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
    // Four all-zero words: lock drops on the fourth, RD forced to -1
    for (int i = 0; i < 3; i++)
      send_word(10'b0000000000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    send_word(10'b0000000000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
    // Idle zeros in HUNT: no pulses expected
    repeat (25) drive_bit(1'b0);
    check("hunt_locked", 32'(o_Locked), 32'h0);
    check("hunt_rd",     32'(o_RD), 32'h3);
    // RD+ comma re-locks, RD becomes -1
    send_word(10'b1100000101, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11);

    // Reset after five bits of a locked word
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    i_rst = 1'b1;
    drive_bit(1'b0);
    check_reset_vals("midrst");
    i_rst = 1'b0;
    repeat (4) drive_bit(1'b0);
    send_word(10'b0011111010, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
    send_word(10'b0110001011, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);

    for (int i = 0; i < 40 && sb.size() != 0; i++) drive_bit(1'b0);
    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
